// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial frame transmitter
//
// Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per clock: start bit (1), WIDTH data bits, optional even-parity bit, then
// GAP idle (low) cycles. The line idles low.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset
//   data_in      in   word to transmit, sampled only on an accepting edge
//   in_valid     in   data_in is valid
//   in_ready     out  high only in IDLE (decoded from state register only)
//   data_out     out  registered serial output
//   frame_active out  registered, high during start/data/parity bits
//   done         out  registered one-cycle pulse in the first gap cycle
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             frame_active,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             parity_q, parity_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             data_out_q, data_out_d;
  logic             frame_active_q, frame_active_d;
  logic             done_q, done_d;
  logic             accept;
  logic             sr_bit;

  assign in_ready     = (state_q == S_IDLE);
  assign accept       = in_ready && in_valid;
  assign sr_bit       = (LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1];
  assign data_out     = data_out_q;
  assign frame_active = frame_active_q;
  assign done         = done_q;

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    parity_d       = parity_q;
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    data_out_d     = 1'b0;
    frame_active_d = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d     = data_in;
          parity_d = ^data_in;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = (PARITY_EN != 0) ? S_PARITY : S_GAP;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
      S_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered alongside the state, so they are decoded from
    // the state being entered. Each edge entering/staying in DATA emits the
    // next shift-register bit and consumes it.
    case (state_d)
      S_START: begin
        data_out_d     = 1'b1;
        frame_active_d = 1'b1;
      end
      S_DATA: begin
        data_out_d     = sr_bit;
        frame_active_d = 1'b1;
        sr_d           = (LSB_FIRST != 0) ? (sr_q >> 1) : (sr_q << 1);
      end
      S_PARITY: begin
        data_out_d     = parity_q;
        frame_active_d = 1'b1;
      end
      S_GAP: begin
        done_d = (state_q != S_GAP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sr_q           <= '0;
      parity_q       <= 1'b0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      data_out_q     <= 1'b0;
      frame_active_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      parity_q       <= parity_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      data_out_q     <= data_out_d;
      frame_active_q <= frame_active_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] vld;
  logic [7:0] din [3];
  wire  [2:0] rdy, dout, fa, dn;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle outputs, packed {in_ready, done, frame_active, data_out}
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  // u0: LSB first, no parity, GAP=1
  serial_frame_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0), .GAP(1)) u0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .data_out(dout[0]), .frame_active(fa[0]), .done(dn[0]));
  // u1: MSB first, no parity, GAP=2
  serial_frame_tx #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0), .GAP(2)) u1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .data_out(dout[1]), .frame_active(fa[1]), .done(dn[1]));
  // u2: LSB first, even parity, GAP=1
  serial_frame_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1), .GAP(1)) u2 (
    .clk(clk), .reset(reset), .data_in(din[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .data_out(dout[2]), .frame_active(fa[2]), .done(dn[2]));

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push_e(int i, logic [3:0] e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic logic [3:0] pop_e(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void flush(int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Reference frame: start, 8 data bits, optional parity, gap cycles.
  function automatic void push_frame(int i, logic [7:0] w);
    bit lsb;
    bit par;
    int gap;
    lsb = (i != 1);
    par = (i == 2);
    gap = (i == 1) ? 2 : 1;
    push_e(i, 4'b0011);
    for (int k = 0; k < 8; k++) push_e(i, {3'b001, lsb ? w[k] : w[7-k]});
    if (par) push_e(i, {3'b001, ^w});
    push_e(i, 4'b0100);
    for (int k = 1; k < gap; k++) push_e(i, 4'b0000);
  endfunction

  function automatic void monitor_one(int i, logic [3:0] act);
    logic [3:0] e;
    if (qsize(i) > 0) begin
      e = pop_e(i);
      check($sformatf("u%0d_stream", i), {28'd0, act}, {28'd0, e});
    end else if (act != 4'b1000) begin
      check($sformatf("u%0d_unexpected", i), {28'd0, act}, 32'h8);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) monitor_one(i, {rdy[i], dn[i], fa[i], dout[i]});
  end

  task automatic send(int i, logic [7:0] w, bit keep);
    int n;
    n = 0;
    din[i] = w;
    vld[i] = 1'b1;
    while (!rdy[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      check($sformatf("u%0d_accept_timeout", i), 32'd0, 32'd1);
      vld[i] = 1'b0;
      return;
    end
    @(posedge clk);
    push_frame(i, w);
    @(negedge clk);
    if (!keep) vld[i] = 1'b0;
  endtask

  task automatic drain(int i);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("u%0d_drain", i), 32'(qsize(i)), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    vld   = 3'b111;
    for (int i = 0; i < 3; i++) din[i] = 8'hFF;

    // Reset held 3 cycles with in_valid high: nothing accepted.
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d_rst_dout", i), {31'd0, dout[i]}, 32'd0);
        check($sformatf("u%0d_rst_active", i), {31'd0, fa[i]}, 32'd0);
        check($sformatf("u%0d_rst_done", i), {31'd0, dn[i]}, 32'd0);
        check($sformatf("u%0d_rst_ready", i), {31'd0, rdy[i]}, 32'd1);
      end
    end
    reset = 1'b0;
    vld   = 3'b000;
    repeat (4) @(negedge clk);

    // Single LSB-first frame 0x01: 1,1,0x7, done at T+10, ready at T+11.
    send(0, 8'h01, 1'b0);
    drain(0);
    @(negedge clk);
    check("u0_ready_return", {31'd0, rdy[0]}, 32'd1);

    // MSB-first 0x01: 1,0x7,1, then two gap cycles.
    send(1, 8'h01, 1'b0);
    drain(1);
    @(negedge clk);
    check("u1_ready_return", {31'd0, rdy[1]}, 32'd1);

    // Parity: 0x07 -> parity 1, 0x03 -> parity 0.
    send(2, 8'h07, 1'b0);
    drain(2);
    @(negedge clk);
    send(2, 8'h03, 1'b0);
    drain(2);
    @(negedge clk);

    // Back-to-back with in_valid held; data_in changes mid-frame.
    send(0, 8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    send(0, 8'h5A, 1'b0);
    drain(0);
    @(negedge clk);

    // Mid-frame reset during the 4th data bit.
    send(0, 8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    flush(0);
    @(negedge clk);
    reset = 1'b0;
    check("u0_abort_dout", {31'd0, dout[0]}, 32'd0);
    check("u0_abort_active", {31'd0, fa[0]}, 32'd0);
    check("u0_abort_done", {31'd0, dn[0]}, 32'd0);
    check("u0_abort_ready", {31'd0, rdy[0]}, 32'd1);
    repeat (3) @(negedge clk);
    send(0, 8'h96, 1'b0);
    drain(0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++)
      check($sformatf("u%0d_leftover", i), 32'(qsize(i)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter. It sits directly upstream of the serial delay-line stage and drives that stage's 1-bit serial input. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock as a frame: start bit, data bits, an optional even-parity bit, then a guaranteed idle gap. The serial line idles low, which matches the downstream stage's reset value.

## Interface
- WIDTH, 8: data word width; legal range 2..32.
- LSB_FIRST, 1: 1 sends data[0] first; 0 sends data[WIDTH-1] first.
- PARITY_EN, 0: 1 appends an even-parity bit after the data bits.
- GAP, 1: minimum number of idle (low) cycles after each frame; legal range ≥1.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- data_in  in  WIDTH  word to transmit; sampled only on an accepting edge.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block can accept a word; high only in IDLE.
- data_out  out  1  registered serial output to the downstream stage.
- frame_active  out  1  registered; high while data_out carries a start, data or parity bit.
- done  out  1  registered; one-cycle pulse in the first GAP cycle after each frame.

## Operation
- States:
  - IDLE: data_out=0, in_ready=1.
  - START: data_out=1.
  - DATA: WIDTH cycles, one data bit per cycle.
  - PARITY: present only when PARITY_EN=1.
  - GAP: data_out=0, lasts GAP cycles.
- Accept: an edge with state==IDLE && in_valid && in_ready. On it, data_in is latched into the shift register, parity=^data_in is latched, and the state moves to START.
- Transitions:
  - IDLE→START on accept; otherwise stay in IDLE.
  - START→DATA.
  - DATA→PARITY, or DATA→GAP if PARITY_EN=0, when the bit counter reaches WIDTH-1.
  - PARITY→GAP.
  - GAP→IDLE when the gap counter reaches GAP-1.
- Bit counter: width $clog2(WIDTH). Cleared on entering DATA, incremented each DATA cycle, no wrap beyond WIDTH-1.
- Shift register:
  - LSB_FIRST=1: shift right; the output bit is sr[0].
  - LSB_FIRST=0: shift left; the output bit is sr[WIDTH-1].
- The latched word is immune to data_in/in_valid changes during a frame. in_valid while not in IDLE is ignored, with no queueing.
- Parity bit value = XOR of all WIDTH latched data bits, so the total count of ones over data plus parity is even.
- in_ready is combinational from the state register only, with no path from in_valid.
- Reset (synchronous): state=IDLE, counters=0, shift register=0, data_out=0, frame_active=0, done=0. After reset, in_ready=1.
- Reset asserted mid-frame aborts the frame. The next cycle shows data_out=0 with no done pulse, and no residual bits are ever emitted.
- in_valid high during the reset edge is not accepted.

## Timing
- Accept at edge T. Then:
  - cycle T+1: start bit (data_out=1, frame_active=1).
  - cycles T+2..T+1+WIDTH: data bits.
  - cycle T+2+WIDTH: parity bit, if PARITY_EN=1.
- Next cycle: GAP begins, with data_out=0, frame_active=0 and done=1 for exactly that one cycle.
- in_ready returns high GAP cycles after GAP begins.
- Back-to-back period, with in_valid held high: 2+WIDTH+PARITY_EN+GAP cycles. Defaults give 11.
- Latency, accept edge to first data bit on data_out: 2 cycles.

## Test plan
- Reset: hold reset high for 3 cycles with in_valid=1 → data_out=0, frame_active=0, done=0, in_ready=1, and no frame starts after release until a new accept.
- Single frame, WIDTH=8, LSB_FIRST=1, data_in=0x01 → data_out from T+1 is 1,1,0,0,0,0,0,0,0, then 0; done pulses at T+10; in_ready returns at T+11.
- MSB first, LSB_FIRST=0, data_in=0x01 → 1,0,0,0,0,0,0,0,1, then 0 with GAP held.
- Parity, PARITY_EN=1:
  - data_in=0x07 → the parity cycle shows 1.
  - data_in=0x03 → the parity cycle shows 0.
  - The done pulse shifts to one cycle after the parity bit.
- Back-to-back: in_valid held high with 0xA5 then 0x5A, data_in changed mid-frame → second start bit 11 cycles after the first; the first frame is unaffected by the data_in change.
- Mid-frame reset: reset for 1 cycle at the 4th data bit → data_out=0 and frame_active=0 the next cycle, no done pulse, in_ready=1, and the next accepted word transmits cleanly.
